// File: rtl/counter_pkg.sv
// Shared types and constants for the ripple-counter observer.
// Direction encoding, unit-step deltas and the modulo-16 delta helper.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQ,
        ST_LOCK
    } state_t;

    localparam logic       DIR_UP   = 1'b0;
    localparam logic       DIR_DN   = 1'b1;
    localparam logic [3:0] DELTA_UP = 4'd1;
    localparam logic [3:0] DELTA_DN = 4'd15;

    function automatic logic [3:0] delta4(input logic [3:0] a, input logic [3:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/count_filter.sv
// Two-flop synchroniser plus stability filter for the asynchronous count bus.
// acc_valid is high on the edge where a candidate has held for STABLE cycles.
module count_filter #(
    parameter int STABLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic       acc_valid,
    output logic [3:0] acc_value
);

    localparam logic [3:0] STABLE_C = 4'(STABLE);

    logic [3:0] s1;
    logic [3:0] s2;
    logic       v1;
    logic       v2;
    logic [3:0] cand;
    logic [3:0] cnt;
    logic       load;

    // A fresh candidate is taken when none is held or the synchronised value moved.
    assign load      = (cnt == 4'd0) || (s2 != cand);
    assign acc_valid = v2 && (load ? (STABLE_C == 4'd1) : (cnt == STABLE_C - 4'd1));
    assign acc_value = s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 4'd0;
            s2   <= 4'd0;
            v1   <= 1'b0;
            v2   <= 1'b0;
            cand <= 4'd0;
            cnt  <= 4'd0;
        end else begin
            s1 <= d;
            s2 <= s1;
            v1 <= 1'b1;
            v2 <= v1;
            if (v2) begin
                if (load) begin
                    cand <= s2;
                    cnt  <= 4'd1;
                end else if (cnt != STABLE_C) begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/counter_monitor.sv
// Observer for a 4-bit ripple up/down counter: filters the bus, recovers the
// direction and reports steps, reversals and illegal jumps.
module counter_monitor
    import counter_pkg::*;
#(
    parameter int STABLE = 2,
    parameter int NW     = 8
) (
    input  logic          C,
    input  logic          R,
    input  logic [3:0]    D,
    output logic [3:0]    Q,
    output logic          M,
    output logic          L,
    output logic          P,
    output logic          F,
    output logic          E,
    output logic [NW-1:0] N
);

    function automatic logic [NW-1:0] sat_inc(input logic [NW-1:0] x);
        return (x == {NW{1'b1}}) ? x : x + {{(NW-1){1'b0}}, 1'b1};
    endfunction

    logic       acc_valid;
    logic [3:0] acc_value;
    logic [3:0] dlt;
    state_t     state;
    state_t     state_n;
    logic [3:0] q_n;
    logic       m_n;
    logic       l_n;
    logic       p_n;
    logic       f_n;
    logic       e_n;

    count_filter #(
        .STABLE(STABLE)
    ) u_filter (
        .clk      (C),
        .rst      (R),
        .d        (D),
        .acc_valid(acc_valid),
        .acc_value(acc_value)
    );

    assign dlt = delta4(acc_value, Q);

    always_comb begin
        state_n = state;
        q_n     = Q;
        m_n     = M;
        l_n     = L;
        p_n     = 1'b0;
        f_n     = 1'b0;
        e_n     = 1'b0;
        if (acc_valid) begin
            q_n = acc_value;
            case (state)
                ST_IDLE: state_n = ST_ACQ;
                ST_ACQ: begin
                    if (dlt == DELTA_UP) begin
                        m_n     = DIR_UP;
                        l_n     = 1'b1;
                        p_n     = 1'b1;
                        state_n = ST_LOCK;
                    end else if (dlt == DELTA_DN) begin
                        m_n     = DIR_DN;
                        l_n     = 1'b1;
                        p_n     = 1'b1;
                        state_n = ST_LOCK;
                    end else if (dlt != 4'd0) begin
                        e_n = 1'b1;
                    end
                end
                ST_LOCK: begin
                    // Delta 0 is a re-accepted value after a transient: nothing happens.
                    if (dlt == 4'd0) begin
                        p_n = 1'b0;
                    end else if ((dlt == DELTA_UP && M == DIR_UP) ||
                                 (dlt == DELTA_DN && M == DIR_DN)) begin
                        p_n = 1'b1;
                    end else if (dlt == DELTA_UP || dlt == DELTA_DN) begin
                        m_n = ~M;
                        f_n = 1'b1;
                    end else begin
                        e_n     = 1'b1;
                        l_n     = 1'b0;
                        state_n = ST_ACQ;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            state <= ST_IDLE;
            Q     <= 4'd0;
            M     <= DIR_UP;
            L     <= 1'b0;
            P     <= 1'b0;
            F     <= 1'b0;
            E     <= 1'b0;
            N     <= '0;
        end else begin
            state <= state_n;
            Q     <= q_n;
            M     <= m_n;
            L     <= l_n;
            P     <= p_n;
            F     <= f_n;
            E     <= e_n;
            if (e_n) begin
                N <= sat_inc(N);
            end
        end
    end

endmodule
